// File: rtl/axi_arb_pkg.sv
// Shared types and fixed AXI field values for the round-robin AXI master arbiter.
// The optional requester-0 priority mode is selected with the ARB_PRIO0_EN macro.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT_B,
        RD,
        WAIT_R,
        RESP
    } arb_state_e;

    localparam logic [2:0] SIZE_64    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection with the last_grant pointer.
// With ARB_PRIO0_EN defined, requester 0 always wins and the rest share round-robin.
module rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [NUM_REQ-1:0]                req,
    input  logic                              grant_en,
    output logic                              grant_valid,
    output logic [idx_width(NUM_REQ)-1:0]     grant_idx
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] rr_req;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
`ifdef ARB_PRIO0_EN
        rr_req      = {req[NUM_REQ-1:1], 1'b0};
`else
        rr_req      = req;
`endif
        // Scan starting just after the previous winner, wrapping modulo NUM_REQ.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!grant_valid && rr_req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
`ifdef ARB_PRIO0_EN
        if (req[0]) begin
            grant_valid = 1'b1;
            grant_idx   = '0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (grant_en) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port between NUM_REQ single-beat requesters, one transaction at a time.
// Arbitration policy is plain round-robin unless ARB_PRIO0_EN is defined.
module axi_master_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic [1:0]                resp_err,
    output logic [ID_W-1:0]           M_AWID,
    output logic [ADDR_W-1:0]         M_AWADDR,
    output logic [7:0]                M_AWLEN,
    output logic [2:0]                M_AWSIZE,
    output logic [1:0]                M_AWBURST,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [DATA_W-1:0]         M_WDATA,
    output logic [DATA_W/8-1:0]       M_WSTRB,
    output logic                      M_WLAST,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    output logic [ID_W-1:0]           M_ARID,
    output logic [ADDR_W-1:0]         M_ARADDR,
    output logic [7:0]                M_ARLEN,
    output logic [2:0]                M_ARSIZE,
    output logic [1:0]                M_ARBURST,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    input  logic [DATA_W-1:0]         M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RLAST,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e        state, state_nxt;
    logic              grant_valid, take_grant;
    logic [IDX_W-1:0]  grant_idx, cur_id;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              aw_done, w_done;

    assign take_grant = (state == IDLE) && grant_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .req         (req_valid),
        .grant_en    (take_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        M_AWVALID  = 1'b0;
        M_WVALID   = 1'b0;
        M_ARVALID  = 1'b0;
        M_BREADY   = 1'b0;
        M_RREADY   = 1'b0;
        unique case (state)
            IDLE: if (grant_valid) begin
                req_ready[grant_idx] = 1'b1;
                state_nxt = req_write[grant_idx] ? WR : RD;
            end
            WR: begin
                // AW and W retire independently; leave once both have, possibly in the same cycle.
                M_AWVALID = !aw_done;
                M_WVALID  = !w_done;
                if ((aw_done || M_AWREADY) && (w_done || M_WREADY)) state_nxt = WAIT_B;
            end
            RD: begin
                M_ARVALID = 1'b1;
                if (M_ARREADY) state_nxt = WAIT_R;
            end
            WAIT_B: begin
                M_BREADY = 1'b1;
                if (M_BVALID) state_nxt = RESP;
            end
            WAIT_R: begin
                M_RREADY = 1'b1;
                if (M_RVALID && M_RLAST) state_nxt = RESP;
            end
            RESP: begin
                resp_valid[cur_id] = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cur_id     <= '0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= RESP_OKAY;
        end else begin
            if (take_grant) begin
                cur_id    <= grant_idx;
                cur_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                cur_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
            end
            if (state == WR) begin
                if (M_AWREADY) aw_done <= 1'b1;
                if (M_WREADY)  w_done  <= 1'b1;
            end
            if (state == WAIT_B && M_BVALID) resp_err <= M_BRESP;
            // Non-final read beats are accepted but never captured.
            if (state == WAIT_R && M_RVALID && M_RLAST) begin
                resp_err   <= M_RRESP;
                resp_rdata <= M_RDATA;
            end
        end
    end

    assign M_AWID    = ID_W'(cur_id);
    assign M_AWADDR  = cur_addr;
    assign M_AWLEN   = 8'd0;
    assign M_AWSIZE  = SIZE_64;
    assign M_AWBURST = BURST_INCR;
    assign M_WDATA   = cur_wdata;
    assign M_WSTRB   = '1;
    assign M_WLAST   = 1'b1;
    assign M_ARID    = ID_W'(cur_id);
    assign M_ARADDR  = cur_addr;
    assign M_ARLEN   = 8'd0;
    assign M_ARSIZE  = SIZE_64;
    assign M_ARBURST = BURST_INCR;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Randomized self-checking bench for axi_master_arbiter against a transaction-level model.
// Grant expectations follow ARB_PRIO0_EN when the macro is defined.
module tb_axi_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int ID_W    = 4;

    logic                      ACLK = 1'b0;
    logic                      ARESETn;
    logic [NUM_REQ-1:0]        req_valid, req_ready, req_write, resp_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]         resp_rdata;
    logic [1:0]                resp_err;
    logic [ID_W-1:0]           M_AWID, M_ARID;
    logic [ADDR_W-1:0]         M_AWADDR, M_ARADDR;
    logic [7:0]                M_AWLEN, M_ARLEN;
    logic [2:0]                M_AWSIZE, M_ARSIZE;
    logic [1:0]                M_AWBURST, M_ARBURST, M_BRESP, M_RRESP;
    logic                      M_AWVALID, M_AWREADY, M_WLAST, M_WVALID, M_WREADY;
    logic [DATA_W-1:0]         M_WDATA, M_RDATA;
    logic [DATA_W/8-1:0]       M_WSTRB;
    logic                      M_BVALID, M_BREADY, M_ARVALID, M_ARREADY;
    logic                      M_RLAST, M_RVALID, M_RREADY;

    always #5 ACLK = ~ACLK;

    axi_master_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
        .M_WREADY(M_WREADY), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RVALID(M_RVALID),
        .M_RREADY(M_RREADY)
    );

    int n_vec = 0;
    int n_err = 0;
    int model_last = NUM_REQ - 1;

    logic [ADDR_W-1:0] r_addr  [NUM_REQ];
    logic [DATA_W-1:0] r_data  [NUM_REQ];
    logic              r_write [NUM_REQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner is the first requesting index after the previous winner, wrapping around.
    function automatic int model_grant(input logic [NUM_REQ-1:0] mask);
`ifdef ARB_PRIO0_EN
        if (mask[0]) return 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            int c = (model_last + off) % NUM_REQ;
            if (c != 0 && mask[c]) return c;
        end
`else
        for (int off = 1; off <= NUM_REQ; off++) begin
            int c = (model_last + off) % NUM_REQ;
            if (mask[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic randomize_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            r_addr[i]  = $urandom;
            r_data[i]  = {$urandom, $urandom};
            r_write[i] = 1'($urandom);
        end
    endtask

    task automatic idle_slave();
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_ARREADY = 1'b0;
        M_BVALID  = 1'b0; M_BRESP  = 2'b00;
        M_RVALID  = 1'b0; M_RLAST  = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
    endtask

    task automatic do_reset_check();
        req_valid = '0;
        idle_slave();
        ARESETn = 1'b0;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_awvalid", M_AWVALID, 0);
        check("rst_wvalid", M_WVALID, 0);
        check("rst_arvalid", M_ARVALID, 0);
        check("rst_bready", M_BREADY, 0);
        check("rst_rready", M_RREADY, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        model_last = NUM_REQ - 1;
        repeat (2) begin
            @(negedge ACLK);
            check("rst_no_resp", resp_valid, 0);
        end
    endtask

    task automatic run_txn(input logic [NUM_REQ-1:0] mask, input int d_aw, input int d_w,
                           input int d_resp, input int n_junk, input logic [1:0] rsp,
                           input logic [DATA_W-1:0] rdata, input bit abort);
        int g, phase, aw_n, w_n, rc, junk_left;
        logic wr;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        g  = model_grant(mask);
        wr = r_write[g];
        ea = r_addr[g];
        ed = r_data[g];
        @(posedge ACLK); #1;
        req_valid = mask;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = r_addr[i];
            req_wdata[i*DATA_W +: DATA_W] = r_data[i];
            req_write[i]                  = r_write[i];
        end
        @(negedge ACLK);
        check("req_ready_grant", req_ready, 64'd1 << g);
        @(posedge ACLK); #1;
        model_last = g;
        // The latched command must not follow the requester inputs after the grant.
        req_valid = NUM_REQ'($urandom);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = $urandom;
            req_wdata[i*DATA_W +: DATA_W] = {$urandom, $urandom};
            req_write[i]                  = 1'($urandom);
        end
        phase = 0; aw_n = 0; w_n = 0; rc = 0; junk_left = n_junk;
        for (int c = 0; c < 64 && phase != 2; c++) begin
            M_AWREADY = (c >= d_aw);
            M_WREADY  = (c >= d_w);
            M_ARREADY = (c >= d_aw);
            M_BVALID  = 1'b0;
            M_BRESP   = rsp;
            M_RVALID  = 1'b0;
            M_RLAST   = 1'b0;
            M_RDATA   = {$urandom, $urandom};
            M_RRESP   = 2'($urandom);
            if (phase == 1) begin
                if (wr) begin
                    M_BVALID = (rc >= d_resp);
                end else begin
                    M_RVALID = (rc >= d_resp) && !abort;
                    M_RLAST  = (junk_left == 0);
                    if (junk_left == 0) begin
                        M_RDATA = rdata;
                        M_RRESP = rsp;
                    end
                end
                rc++;
            end
            @(negedge ACLK);
            check("req_ready_busy", req_ready, 0);
            check("resp_valid_busy", resp_valid, 0);
            if (phase == 0) begin
                check("bready_addr", M_BREADY, 0);
                check("rready_addr", M_RREADY, 0);
                if (wr) begin
                    check("arvalid_on_write", M_ARVALID, 0);
                    check("awvalid", M_AWVALID, 64'(aw_n == 0));
                    check("wvalid", M_WVALID, 64'(w_n == 0));
                    if (M_AWVALID && M_AWREADY) begin
                        aw_n++;
                        check("awaddr", M_AWADDR, ea);
                        check("awid", M_AWID, 64'(g));
                        check("awlen", M_AWLEN, 0);
                        check("awsize", M_AWSIZE, 3'b011);
                        check("awburst", M_AWBURST, 2'b01);
                    end
                    if (M_WVALID && M_WREADY) begin
                        w_n++;
                        check("wdata", M_WDATA, ed);
                        check("wstrb", M_WSTRB, 8'hFF);
                        check("wlast", M_WLAST, 1);
                    end
                    if (aw_n > 0 && w_n > 0) phase = 1;
                end else begin
                    check("awvalid_on_read", M_AWVALID, 0);
                    check("wvalid_on_read", M_WVALID, 0);
                    check("arvalid", M_ARVALID, 1);
                    if (M_ARVALID && M_ARREADY) begin
                        check("araddr", M_ARADDR, ea);
                        check("arid", M_ARID, 64'(g));
                        check("arlen", M_ARLEN, 0);
                        check("arsize", M_ARSIZE, 3'b011);
                        check("arburst", M_ARBURST, 2'b01);
                        phase = 1;
                    end
                end
            end else begin
                check("awvalid_resp", M_AWVALID, 0);
                check("wvalid_resp", M_WVALID, 0);
                check("arvalid_resp", M_ARVALID, 0);
                if (wr) begin
                    check("bready", M_BREADY, 1);
                    check("rready_on_write", M_RREADY, 0);
                    if (M_BVALID) phase = 2;
                end else begin
                    check("rready", M_RREADY, 1);
                    check("bready_on_read", M_BREADY, 0);
                    if (abort) begin
                        @(posedge ACLK); #1;
                        do_reset_check();
                        return;
                    end
                    if (M_RVALID) begin
                        if (M_RLAST) phase = 2;
                        else junk_left--;
                    end
                end
            end
            @(posedge ACLK); #1;
        end
        idle_slave();
        req_valid = '0;
        check("txn_complete", phase, 2);
        check("aw_beats", aw_n, wr ? 1 : 0);
        check("w_beats", w_n, wr ? 1 : 0);
        @(negedge ACLK);
        check("resp_valid", resp_valid, 64'd1 << g);
        check("resp_err", resp_err, rsp);
        if (!wr) check("resp_rdata", resp_rdata, rdata);
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check("resp_valid_one_cycle", resp_valid, 0);
    endtask

    initial begin
        ARESETn   = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        idle_slave();
        randomize_reqs();
        #1;
        do_reset_check();

        r_addr[2] = 32'h1000; r_data[2] = 64'hFACECAFEDEADBEEF; r_write[2] = 1'b1;
        run_txn(4'b0100, 0, 0, 0, 0, 2'b00, 64'h0, 1'b0);

        r_addr[1] = 32'h1000; r_write[1] = 1'b0;
        run_txn(4'b0010, 0, 0, 0, 0, 2'b00, 64'h1234, 1'b0);

        // Late W after AW, same-cycle AW/W, and late AW after W.
        r_write[3] = 1'b1;
        run_txn(4'b1000, 0, 3, 0, 0, 2'b00, 64'h0, 1'b0);
        run_txn(4'b1000, 0, 0, 0, 0, 2'b00, 64'h0, 1'b0);
        run_txn(4'b1000, 3, 0, 1, 0, 2'b00, 64'h0, 1'b0);

        r_write[0] = 1'b1;
        run_txn(4'b0001, 0, 0, 2, 0, 2'b10, 64'h0, 1'b0);

        // Read with discarded early beats, then a read aborted by reset in WAIT_R.
        r_write[1] = 1'b0;
        run_txn(4'b0010, 1, 0, 1, 2, 2'b01, 64'hC0FFEE0012345678, 1'b0);
        r_write[2] = 1'b0;
        run_txn(4'b0100, 0, 0, 0, 0, 2'b00, 64'h0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            randomize_reqs();
            run_txn(4'b1111, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 1), 2'($urandom), {$urandom, $urandom}, 1'b0);
        end

        for (int t = 0; t < 3; t++) begin
            randomize_reqs();
            run_txn(4'b1001, 0, 0, 0, 0, 2'b00, {$urandom, $urandom}, 1'b0);
        end
        randomize_reqs();
        run_txn(4'b1000, 0, 0, 0, 0, 2'b00, {$urandom, $urandom}, 1'b0);

        for (int t = 0; t < 40; t++) begin
            randomize_reqs();
            run_txn(NUM_REQ'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 2), 2'($urandom),
                    {$urandom, $urandom}, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
